pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_fade_pkg.sv | 30 +++
 rtl/pwm_frame_timer.sv | 25 ++
 rtl/pwm_fade_ctrl.sv | 126 ++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_fade_pkg.sv
// Shared types and constants for the PWM fade controller.
// Holds the FSM state encoding, the frame length and the step arithmetic.
package pwm_fade_pkg;

    localparam logic [7:0] FRAME_LAST = 8'hFE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fade_state_e;

    // Move lvl toward tgt by stp in 9 bits; clamp so we never pass tgt.
    function automatic logic [7:0] fade_step(
        input logic [7:0] lvl,
        input logic [7:0] tgt,
        input logic [7:0] stp
    );
        logic [8:0] sum;
        logic [8:0] dif;
        sum = {1'b0, lvl} + {1'b0, stp};
        dif = {1'b0, lvl} - {1'b0, stp};
        if (lvl < tgt) begin
            fade_step = (sum >= {1'b0, tgt}) ? tgt : sum[7:0];
        end else begin
            fade_step = (dif[8] || dif[7:0] <= tgt) ? tgt : dif[7:0];
        end
    endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// Free-running PWM frame counter, 0..FRAME_LAST.
// frame_end marks the last cycle of every frame.
module pwm_frame_timer
    import pwm_fade_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    output logic frame_end
);

    logic [7:0] frame_cnt;

    assign frame_end = (frame_cnt == FRAME_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= 8'd0;
        end else if (frame_end) begin
            frame_cnt <= 8'd0;
        end else begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM level fader: steps level toward a target once every (div+1) frames.
// Also supports immediate level writes while idle.
module pwm_fade_ctrl
    import pwm_fade_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] cfg_target,
    input  logic [7:0] cfg_step,
    input  logic [7:0] cfg_div,
    input  logic       cfg_wr,
    input  logic [7:0] force_level,
    input  logic       force_wr,
    input  logic       start,
    input  logic       abort,
    output logic [7:0] level,
    output logic       set_level,
    output logic       busy,
    output logic       done
);

    fade_state_e state, state_nxt;

    logic [7:0] target, step, div, div_cnt;
    logic [7:0] tgt_eff, step_eff, div_eff;
    logic [7:0] step_val;
    logic       frame_end;
    logic       ld_cfg, ld_force, go_run, do_step, do_count;

    pwm_frame_timer u_timer (
        .clk       (clk),
        .rstn      (rstn),
        .frame_end (frame_end)
    );

    // A start in the same cycle as cfg_wr sees the new settings.
    assign tgt_eff  = cfg_wr ? cfg_target : target;
    assign step_eff = cfg_wr ? cfg_step   : step;
    assign div_eff  = cfg_wr ? cfg_div    : div;
    assign step_val = fade_step(level, target, step);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_cfg    = 1'b0;
        ld_force  = 1'b0;
        go_run    = 1'b0;
        do_step   = 1'b0;
        do_count  = 1'b0;
        unique case (state)
            IDLE: begin
                ld_cfg = cfg_wr;
                if (force_wr) begin
                    ld_force = 1'b1;
                end else if (start) begin
                    if (step_eff == 8'd0 || level == tgt_eff) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                        go_run    = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (frame_end) begin
                    if (div_cnt == 8'd0) begin
                        do_step = 1'b1;
                        if (step_val == target) begin
                            state_nxt = DONE;
                        end
                    end else begin
                        do_count = 1'b1;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level     <= 8'd0;
            set_level <= 1'b0;
            target    <= 8'd0;
            step      <= 8'd0;
            div       <= 8'd0;
            div_cnt   <= 8'd0;
        end else begin
            set_level <= 1'b0;
            if (ld_cfg) begin
                target <= cfg_target;
                step   <= cfg_step;
                div    <= cfg_div;
            end
            if (ld_force) begin
                level     <= force_level;
                set_level <= 1'b1;
            end
            if (go_run) begin
                div_cnt <= div_eff;
            end
            if (do_step) begin
                level     <= step_val;
                set_level <= 1'b1;
                div_cnt   <= div;
            end
            if (do_count) begin
                div_cnt <= div_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed self-checking bench for pwm_fade_ctrl.
// A local frame counter model tracks where each frame starts.
module tb_pwm_fade_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] cfg_target, cfg_step, cfg_div, force_level;
    logic       cfg_wr, force_wr, start, abort;
    logic [7:0] level;
    logic       set_level, busy, done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_pulse = 0;
    int tb_fc = 0;

    pwm_fade_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_target  (cfg_target),
        .cfg_step    (cfg_step),
        .cfg_div     (cfg_div),
        .cfg_wr      (cfg_wr),
        .force_level (force_level),
        .force_wr    (force_wr),
        .start       (start),
        .abort       (abort),
        .level       (level),
        .set_level   (set_level),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) tb_fc <= 0;
        else tb_fc <= (tb_fc == 254) ? 0 : tb_fc + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cfg_wr = 1'b0;
        force_wr = 1'b0;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic do_force(input logic [7:0] v);
        force_level = v;
        force_wr = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic do_cfg(input logic [7:0] t, input logic [7:0] s,
                          input logic [7:0] d, input logic st);
        cfg_target = t;
        cfg_step = s;
        cfg_div = d;
        cfg_wr = 1'b1;
        start = st;
        tick();
        idle_inputs();
    endtask

    // Waits for the next set_level pulse and checks its level and timing.
    task automatic wait_pulse(input string tag, input logic [7:0] exp,
                              input int gap);
        int n;
        n = 0;
        tick();
        while (set_level !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, {31'd0, set_level}, 32'd1);
        chk({tag, "_level"}, {24'd0, level}, {24'd0, exp});
        chk({tag, "_fc0"}, tb_fc, 0);
        if (gap > 0) chk({tag, "_gap"}, cyc - last_pulse, gap);
        last_pulse = cyc;
    endtask

    task automatic watch_quiet(input string tag, input int n);
        int sl, dn;
        sl = 0;
        dn = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (set_level) sl++;
            if (done) dn++;
        end
        chk({tag, "_no_set"}, sl, 0);
        chk({tag, "_no_done"}, dn, 0);
    endtask

    initial begin
        rstn = 1'b0;
        cfg_target = 8'd0;
        cfg_step = 8'd0;
        cfg_div = 8'd0;
        force_level = 8'd0;
        idle_inputs();
        #12;
        chk("rst_level", {24'd0, level}, 32'd0);
        chk("rst_set", {31'd0, set_level}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        tick();
        rstn = 1'b1;
        tick();

        // immediate level write
        do_force(8'h40);
        chk("force_level", {24'd0, level}, 32'h40);
        chk("force_set", {31'd0, set_level}, 32'd1);
        chk("force_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("force_set_once", {31'd0, set_level}, 32'd0);

        // fade up, cfg and start together
        do_force(8'd0);
        do_cfg(8'd100, 8'd30, 8'd0, 1'b1);
        chk("up_busy", {31'd0, busy}, 32'd1);
        chk("up_noset", {31'd0, set_level}, 32'd0);
        wait_pulse("up1", 8'd30, 0);
        chk("up1_busy", {31'd0, busy}, 32'd1);
        wait_pulse("up2", 8'd60, 255);
        wait_pulse("up3", 8'd90, 255);
        wait_pulse("up4", 8'd100, 255);
        chk("up_done", {31'd0, done}, 32'd1);
        chk("up_end_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("up_done_once", {31'd0, done}, 32'd0);

        // fade down with divider, clamp at target
        do_force(8'd200);
        do_cfg(8'd10, 8'd64, 8'd2, 1'b0);
        start = 1'b1;
        tick();
        idle_inputs();
        wait_pulse("dn1", 8'd136, 0);
        wait_pulse("dn2", 8'd72, 765);
        wait_pulse("dn3", 8'd10, 765);
        chk("dn_done", {31'd0, done}, 32'd1);
        tick();
        chk("dn_idle", {31'd0, busy}, 32'd0);

        // abort on the cycle a step is due; cfg in RUN ignored
        do_force(8'd0);
        do_cfg(8'd200, 8'd50, 8'd0, 1'b1);
        do_cfg(8'd5, 8'd1, 8'd0, 1'b0);
        for (int i = 0; i < 300 && tb_fc != 254; i++) tick();
        chk("ab_align", tb_fc, 254);
        abort = 1'b1;
        tick();
        idle_inputs();
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_set", {31'd0, set_level}, 32'd0);
        chk("ab_level", {24'd0, level}, 32'd0);
        watch_quiet("ab_quiet", 300);

        // restart uses the values latched before RUN
        start = 1'b1;
        tick();
        idle_inputs();
        wait_pulse("rs1", 8'd50, 0);
        abort = 1'b1;
        tick();
        idle_inputs();
        chk("rs_ab_busy", {31'd0, busy}, 32'd0);
        chk("rs_ab_done", {31'd0, done}, 32'd0);
        chk("rs_ab_level", {24'd0, level}, 32'd50);

        // degenerate starts: step zero, level at target
        do_cfg(8'd99, 8'd0, 8'd0, 1'b1);
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_busy", {31'd0, busy}, 32'd0);
        chk("z_set", {31'd0, set_level}, 32'd0);
        tick();
        chk("z_done_once", {31'd0, done}, 32'd0);
        do_cfg(8'd50, 8'd5, 8'd0, 1'b1);
        chk("eq_done", {31'd0, done}, 32'd1);
        chk("eq_set", {31'd0, set_level}, 32'd0);
        chk("eq_level", {24'd0, level}, 32'd50);
        tick();

        // force beats start in the same cycle
        force_level = 8'd7;
        force_wr = 1'b1;
        start = 1'b1;
        tick();
        idle_inputs();
        chk("fs_level", {24'd0, level}, 32'd7);
        chk("fs_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("fs_still_idle", {31'd0, busy}, 32'd0);

        // async reset mid-fade
        do_cfg(8'd255, 8'd1, 8'd0, 1'b1);
        wait_pulse("ar1", 8'd8, 0);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_level", {24'd0, level}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_set", {31'd0, set_level}, 32'd0);
        chk("ar_done", {31'd0, done}, 32'd0);
        tick();
        rstn = 1'b1;
        watch_quiet("ar_quiet", 600);
        chk("ar_level_hold", {24'd0, level}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
